spw_rx_credit_ctrl: RTL and testbench

- Receive-side flow-control credit scheduler for the SpaceWire receiver.
- Tracks how many N-chars the far end may still send, and requests FCT transmission from the TX side whenever the receive FIFO can absorb another 8 chars.
- Flags credit violations (an N-char arriving with zero credit) to the link FSM.
- Sits between the RX decoder / receive FIFO and the TX FCT send logic, in the pclk domain.

---
 rtl/spw_rx_credit_ctrl.sv | 113 +++++++++++
 tb/tb_spw_rx_credit_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/spw_rx_credit_ctrl.sv
// SpaceWire receive-side FCT credit scheduler: grants credit in CREDIT_STEP chunks and flags credit violations.
// Optional build macro SPW_RX_CREDIT_STATS_EN adds the fct_count/char_count statistics ports.
module spw_rx_credit_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned CREDIT_MAX  = 56,
  parameter int unsigned CREDIT_STEP = 8
) (
  input  logic                                pclk,
  input  logic                                resetn,
  input  logic                                link_run,
  input  logic                                rx_char_valid,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_free,
  output logic                                fct_req,
  input  logic                                fct_ack,
  output logic [$clog2(CREDIT_MAX+1)-1:0]     rx_credit,
  output logic                                credit_error
`ifdef SPW_RX_CREDIT_STATS_EN
  ,
  output logic [15:0]                         fct_count,
  output logic [15:0]                         char_count
`endif
);

  localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned CW = $clog2(CREDIT_MAX + 1);
  // Comparison width wide enough that rx_credit + CREDIT_STEP never truncates
  localparam int unsigned SW = (FW > CW) ? FW : CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   credit_d;
  logic            err_d;
  logic [SW-1:0]   credit_target;
  logic            room_in_fifo;
  logic            under_max;
  logic            ack_ok;
  logic            violation;

  assign credit_target = SW'(rx_credit) + SW'(CREDIT_STEP);
  assign room_in_fifo  = SW'(fifo_free) >= credit_target;
  assign under_max     = credit_target <= SW'(CREDIT_MAX);
  assign ack_ok        = link_run && (state_q == REQ) && fct_ack && under_max;
  assign violation     = rx_char_valid && (rx_credit == '0) && !ack_ok;

  // Next-state, credit arithmetic and sticky error
  always_comb begin
    state_d  = state_q;
    credit_d = rx_credit;
    err_d    = credit_error;
    if (!link_run) begin
      state_d  = IDLE;
      credit_d = '0;
      err_d    = 1'b0;
    end else begin
      if (ack_ok && rx_char_valid) begin
        credit_d = rx_credit + CW'(CREDIT_STEP - 1);
      end else if (ack_ok) begin
        credit_d = rx_credit + CW'(CREDIT_STEP);
      end else if (rx_char_valid && (rx_credit != '0)) begin
        credit_d = rx_credit - CW'(1);
      end

      if (violation) begin
        err_d   = 1'b1;
        state_d = ERR;
      end else begin
        case (state_q)
          IDLE: if (!credit_error && room_in_fifo && under_max) state_d = REQ;
          REQ:  if (ack_ok) state_d = HOLD;
          HOLD: state_d = IDLE;
          ERR:  state_d = ERR;
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and registered outputs; fct_req mirrors the REQ state
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      rx_credit    <= '0;
      fct_req      <= 1'b0;
      credit_error <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_credit    <= credit_d;
      fct_req      <= (state_d == REQ);
      credit_error <= err_d;
    end
  end

`ifdef SPW_RX_CREDIT_STATS_EN
  // Statistics survive link restarts; only resetn clears them
  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      fct_count  <= '0;
      char_count <= '0;
    end else begin
      fct_count  <= fct_count + 16'(ack_ok);
      char_count <= char_count + 16'(rx_char_valid);
    end
  end
`endif

endmodule

// File: tb/tb_spw_rx_credit_ctrl.sv
// Directed self-checking bench for spw_rx_credit_ctrl with a credit scoreboard.
module tb_spw_rx_credit_ctrl;

  logic       pclk;
  logic       resetn;
  logic       link_run;
  logic       rx_char_valid;
  logic [6:0] fifo_free;
  logic       fct_req;
  logic       fct_ack;
  logic [5:0] rx_credit;
  logic       credit_error;
`ifdef SPW_RX_CREDIT_STATS_EN
  logic [15:0] fct_count;
  logic [15:0] char_count;
`endif

  int checks     = 0;
  int failures   = 0;
  int exp_credit = 0;
  int exp_fct    = 0;
  int exp_char   = 0;
  int sb_q[$];

  spw_rx_credit_ctrl dut (
    .pclk          (pclk),
    .resetn        (resetn),
    .link_run      (link_run),
    .rx_char_valid (rx_char_valid),
    .fifo_free     (fifo_free),
    .fct_req       (fct_req),
    .fct_ack       (fct_ack),
    .rx_credit     (rx_credit),
    .credit_error  (credit_error)
`ifdef SPW_RX_CREDIT_STATS_EN
    ,
    .fct_count     (fct_count),
    .char_count    (char_count)
`endif
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (fct_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk(tag, 32'(fct_req), 32'd1);
  endtask

  // Acknowledge the pending request two cycles after it was seen
  task automatic ack_one(input string tag, input bit with_char);
    step();
    chk({tag, "_held1"}, 32'(fct_req), 32'd1);
    step();
    chk({tag, "_held2"}, 32'(fct_req), 32'd1);
    fct_ack       = 1'b1;
    rx_char_valid = with_char;
    exp_credit    = exp_credit + (with_char ? 7 : 8);
    exp_fct++;
    if (with_char) exp_char++;
    sb_q.push_back(exp_credit);
    step();
    fct_ack       = 1'b0;
    rx_char_valid = 1'b0;
    chk(tag, 32'(rx_credit), 32'(sb_q.pop_front()));
    chk({tag, "_hold"}, 32'(fct_req), 32'd0);
  endtask

  task automatic clear_link();
    link_run = 1'b0;
    step();
    exp_credit = 0;
    chk("clear_credit", 32'(rx_credit), 32'd0);
    link_run = 1'b1;
  endtask

  initial begin
    resetn        = 1'b0;
    link_run      = 1'b0;
    rx_char_valid = 1'b0;
    fct_ack       = 1'b0;
    fifo_free     = 7'd0;
    step();
    step();
    chk("rst_req", 32'(fct_req), 32'd0);
    chk("rst_credit", 32'(rx_credit), 32'd0);
    chk("rst_err", 32'(credit_error), 32'd0);
    resetn    = 1'b1;
    link_run  = 1'b1;
    fifo_free = 7'd64;

    // Basic grant: seven FCTs up to CREDIT_MAX, then silence
    for (int i = 1; i <= 7; i++) begin
      wait_req($sformatf("grant%0d_req", i));
      ack_one($sformatf("grant%0d", i), 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("grant_max_noreq", 32'(fct_req), 32'd0);
    end

    // Credit consumption and refill
    for (int i = 0; i < 8; i++) begin
      rx_char_valid = 1'b1;
      exp_credit--;
      exp_char++;
      step();
    end
    rx_char_valid = 1'b0;
    chk("consume_credit", 32'(rx_credit), 32'(exp_credit));
    chk("consume_noreq", 32'(fct_req), 32'd0);
    step();
    chk("refill_lat", 32'(fct_req), 32'd1);
    ack_one("refill", 1'b0);

    // FIFO limit
    fifo_free = 7'd8;
    clear_link();
    wait_req("lim0_req");
    ack_one("lim0", 1'b0);
    fifo_free = 7'd20;
    wait_req("lim20_req");
    ack_one("lim20", 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lim20_noreq", 32'(fct_req), 32'd0);
    end
    fifo_free = 7'd24;
    step();
    chk("lim24_lat", 32'(fct_req), 32'd1);
    ack_one("lim24", 1'b0);

    // Simultaneous char and ack at credit 16
    fifo_free = 7'd64;
    clear_link();
    wait_req("sim_req0");
    ack_one("sim0", 1'b0);
    wait_req("sim_req1");
    ack_one("sim1", 1'b0);
    wait_req("sim_req2");
    ack_one("simul", 1'b1);
    chk("simul_err", 32'(credit_error), 32'd0);

    // Violation and recovery
    fifo_free = 7'd0;
    clear_link();
    step();
    step();
    chk("viol_pre_noreq", 32'(fct_req), 32'd0);
    rx_char_valid = 1'b1;
    exp_char++;
    step();
    rx_char_valid = 1'b0;
    chk("viol_err", 32'(credit_error), 32'd1);
    chk("viol_credit", 32'(rx_credit), 32'd0);
    fifo_free = 7'd64;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("viol_noreq", 32'(fct_req), 32'd0);
    end
    chk("viol_sticky", 32'(credit_error), 32'd1);
    link_run = 1'b0;
    step();
    exp_credit = 0;
    chk("viol_cleared", 32'(credit_error), 32'd0);
    link_run = 1'b1;
    wait_req("recover_req");
    ack_one("recover", 1'b0);

    // Asynchronous reset while a request is pending
    wait_req("mid_req");
`ifdef SPW_RX_CREDIT_STATS_EN
    chk("stats_fct", 32'(fct_count), 32'(exp_fct));
    chk("stats_char", 32'(char_count), 32'(exp_char));
`endif
    resetn = 1'b0;
    #1;
    chk("async_req", 32'(fct_req), 32'd0);
    chk("async_credit", 32'(rx_credit), 32'd0);
    chk("async_err", 32'(credit_error), 32'd0);
`ifdef SPW_RX_CREDIT_STATS_EN
    chk("async_fct_count", 32'(fct_count), 32'd0);
    chk("async_char_count", 32'(char_count), 32'd0);
`endif
    step();
    resetn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
